// File: rtl/seq_divider_8x4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor over 8 cycles,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider_8x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [3:0] B,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] dq_q, dq_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] bl_q, bl_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       done_q, done_d;
    logic       dz_q, dz_d;
    logic       pend_q, pend_d;

    logic [4:0] t;
    logic       qbit;
    logic [3:0] rem_sub;
    logic [3:0] rem_nx;
    logic [7:0] dq_nx;

    // One restoring step; the low 4 bits of t-bl are exact because rem < bl.
    always_comb begin
        t       = {rem_q, dq_q[7]};
        qbit    = (t >= {1'b0, bl_q});
        rem_sub = t[3:0] - bl_q;
        rem_nx  = qbit ? rem_sub : t[3:0];
        dq_nx   = {dq_q[6:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        bl_d    = bl_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero divisor is reported one edge after acceptance, without entering RUN.
                if (pend_q) begin
                    q_d    = 8'hFF;
                    r_d    = '0;
                    dz_d   = 1'b1;
                    done_d = 1'b1;
                end else if (start) begin
                    if (B != 4'd0) begin
                        dq_d    = A;
                        rem_d   = '0;
                        bl_d    = B;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = RUN;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                dq_d  = dq_nx;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    q_d     = dq_nx;
                    r_d     = rem_nx;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dq_q    <= '0;
            rem_q   <= '0;
            bl_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            bl_q    <= bl_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            pend_q  <= pend_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_seq_divider_8x4.sv
// Self-checking bench for seq_divider_8x4: directed cases, an exhaustive sweep
// and random operands against an arithmetic reference model.
module tb_seq_divider_8x4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [3:0] B;
    logic [7:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dz;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    seq_divider_8x4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Waits (bounded) for done after the edge sampled just before the call; returns cycles and busy count.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy && done) check_eq("busy_and_done", 1, 0);
            if (busy) busy_cnt++;
        end
        check_eq("done_seen", done, 1);
    endtask

    task automatic run_div(input logic [7:0] a, input logic [3:0] b);
        int lat, bc;
        logic [7:0] eq;
        logic [3:0] er;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operand changes after acceptance must not matter.
        A = 8'($urandom); B = 4'($urandom);
        bc = busy ? 1 : 0;
        begin
            int l2, b2;
            wait_done(l2, b2);
            lat = l2; bc += b2;
        end
        if (b == 0) begin
            check_eq("dz_latency", lat, 1);
            check_eq("dz_busy", bc, 0);
            check_eq("dz_Q", Q, 8'hFF);
            check_eq("dz_R", R, 0);
            check_eq("dz_flag", dz, 1);
        end else begin
            eq = a / b;
            er = 4'(a % b);
            check_eq("latency", lat, 8);
            check_eq("busy_cycles", bc, 8);
            check_eq("Q", Q, eq);
            check_eq("R", R, er);
            check_eq("dz_clear", dz, 0);
            check_eq("identity", 32'(Q) * 32'(b) + 32'(R), 32'(a));
            check_eq("rem_lt_div", (R < b) ? 1 : 0, 1);
        end
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 0);
    endtask

    initial begin
        int lat, bc;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_Q", Q, 0);
        check_eq("rst_R", R, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_dz", dz, 0);
        rst = 1'b0;

        run_div(8'd143, 4'd13);
        run_div(8'd200, 4'd15);
        run_div(8'd7,   4'd9);
        run_div(8'd255, 4'd1);
        run_div(8'd100, 4'd0);
        run_div(8'd100, 4'd10);

        // Start ignored while busy, then back-to-back start in the done cycle.
        @(negedge clk);
        A = 8'd50; B = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        A = 8'd9; B = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check_eq("ign_Q", Q, 7);
        check_eq("ign_R", R, 1);
        A = 8'd9; B = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("b2b_busy", busy, 1);
        wait_done(lat, bc);
        check_eq("b2b_lat", lat, 8);
        check_eq("b2b_Q", Q, 3);
        check_eq("b2b_R", R, 0);

        // Reset in the 4th busy cycle aborts with no done.
        @(negedge clk);
        A = 8'd200; B = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_Q", Q, 0);
        check_eq("abort_R", R, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_dz", dz, 0);
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) bc++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_done", bc, 0);
        run_div(8'd200, 4'd3);

        for (int b = 1; b < 16; b++)
            for (int a = 0; a < 256; a++)
                run_div(8'(a), 4'(b));

        for (int i = 0; i < 200; i++)
            run_div(8'($urandom), 4'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
